lut_mult_seq_ctrl: RTL and testbench

Nibble-serial sequencer that computes a 16-bit unsigned operand times a fixed constant using a single 4-bit-digit constant-multiplication LUT, one lookup per cycle. It sits in front of the LUT multiplier datapath. It owns the operand register, the digit counter, the shift-accumulate register and a valid/ready handshake on both input and output. This lets one LUT slice serve operands wider than 8 bits.

---
 rtl/lut_mult_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_lut_mult_seq_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/lut_mult_seq_ctrl.sv
// Nibble-serial constant multiplier sequencer: out_c = in_x * A_CONST,
// one 4-bit digit LUT lookup per cycle, MSB digit first.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake, in_x = operand
//   out_valid/out_ready product handshake, out_c = product
//   busy                high while an operation is in flight
module lut_mult_seq_ctrl #(
  parameter int unsigned A_CONST = 2,
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned A_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4*NIBBLES-1:0]         in_x,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*NIBBLES+A_WIDTH-1:0] out_c,
  output logic                         busy
);

  localparam int unsigned XW = 4 * NIBBLES;
  localparam int unsigned OW = XW + A_WIDTH;
  localparam int unsigned LW = A_WIDTH + 4;
  localparam int unsigned CW =
    (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [XW-1:0] x_q, x_d;
  logic [OW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]    nib;
  logic          last;
  logic [LW-1:0] lut [16];

  // Digit products d*A_CONST, fixed at elaboration.
  for (genvar d = 0; d < 16; d++) begin : g_lut
    assign lut[d] = LW'(d * A_CONST);
  end

  assign last = (cnt_q == CW'(NIBBLES - 1));

  // Digit select: cnt 0 picks the most significant nibble.
  always_comb begin
    nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt_q == CW'(NIBBLES - 1 - i)) begin
        nib = x_q[4*i +: 4];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = S_RUN;
      S_RUN:  if (last) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_RUN:  busy = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath: operand capture and shift-accumulate
  always_comb begin
    x_d   = x_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (state_q == S_IDLE && in_valid) begin
      x_d   = in_x;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == S_RUN) begin
      // Product fits OW exactly, so truncation never loses bits.
      acc_d = (acc_q << 4) + OW'(lut[nib]);
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      x_q   <= x_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_c = acc_q;

endmodule

// File: tb/tb_lut_mult_seq_ctrl.sv
// Bench for lut_mult_seq_ctrl: three instances (A_CONST 2/255/17)
// share one stimulus stream; expectations come from x*A arithmetic.
module tb_lut_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_x;

  logic ir2, ir255, ir17;
  logic ov2, ov255, ov17;
  logic bz2, bz255, bz17;
  logic [23:0] c2, c255, c17;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  lut_mult_seq_ctrl #(.A_CONST(2)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir2), .in_x(in_x),
    .out_valid(ov2), .out_ready(out_ready),
    .out_c(c2), .busy(bz2)
  );

  lut_mult_seq_ctrl #(.A_CONST(255)) u255 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir255), .in_x(in_x),
    .out_valid(ov255), .out_ready(out_ready),
    .out_c(c255), .busy(bz255)
  );

  lut_mult_seq_ctrl #(.A_CONST(17)) u17 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir17), .in_x(in_x),
    .out_valid(ov17), .out_ready(out_ready),
    .out_c(c17), .busy(bz17)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic ir,
                           input logic ov, input logic bz);
    chk({tag, ".in_ready"}, 32'({ir2, ir255, ir17}), 32'({3{ir}}));
    chk({tag, ".out_valid"}, 32'({ov2, ov255, ov17}), 32'({3{ov}}));
    chk({tag, ".busy"}, 32'({bz2, bz255, bz17}), 32'({3{bz}}));
  endtask

  task automatic chk_prod(input string tag, input logic [15:0] x);
    logic [31:0] xe;
    xe = {16'h0, x};
    chk({tag, ".c2"}, 32'(c2), xe * 32'd2);
    chk({tag, ".c255"}, 32'(c255), xe * 32'd255);
    chk({tag, ".c17"}, 32'(c17), xe * 32'd17);
  endtask

  // Accept x, check latency, hold DONE for `hold` cycles, then drain.
  // With pend set, a second operand is offered during DONE.
  task automatic run_op(input logic [15:0] x, input int hold,
                        input logic pend);
    in_valid  = 1'b1;
    in_x      = x;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_x     = 16'($urandom);
    chk_flags("accept", 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_flags("run", 1'b0, 1'b0, 1'b1);
    end
    tick();
    chk_flags("done", 1'b0, 1'b1, 1'b1);
    chk_prod("prod", x);
    for (int i = 0; i < hold; i++) begin
      if (pend) begin
        in_valid = 1'b1;
        in_x     = 16'h0F0F;
      end
      tick();
      chk_flags("hold", 1'b0, 1'b1, 1'b1);
      chk_prod("hold", x);
    end
    out_ready = 1'b1;
    tick();
    chk_flags("xfer", 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
  endtask

  logic [15:0] q[$];
  logic [15:0] xp;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_x      = 16'h0;
    #2;
    chk_flags("reset", 1'b1, 1'b0, 1'b0);
    chk_prod("reset", 16'h0);
    #1 rst_n = 1'b1;

    run_op(16'h1234, 0, 1'b0);
    run_op(16'hFFFF, 0, 1'b0);
    run_op(16'h0000, 0, 1'b0);
    run_op(16'hF000, 0, 1'b0);
    run_op(16'h000F, 0, 1'b0);

    // Backpressure with an operand waiting; it must be taken
    // only on the edge after the drain edge.
    run_op(16'h5A5A, 10, 1'b1);
    run_op(16'h0F0F, 0, 1'b0);

    // Asynchronous reset two cycles after accept
    in_valid = 1'b1;
    in_x     = 16'hABCD;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_flags("async_rst", 1'b1, 1'b0, 1'b0);
    chk_prod("async_rst", 16'h0);
    #2 rst_n = 1'b1;
    run_op(16'h0003, 0, 1'b0);

    // Back-to-back: 100 random operands, both handshakes held high.
    // Phase 0 = IDLE offering, 1..4 = RUN, 5 = DONE.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_x      = 16'($urandom);
    for (int cyc = 0; cyc < 600; cyc++) begin
      int ph;
      ph = cyc % 6;
      chk("b2b.in_ready", 32'({ir2, ir255, ir17}),
          32'({3{ph == 0}}));
      chk("b2b.out_valid", 32'({ov2, ov255, ov17}),
          32'({3{ph == 5}}));
      if (ph == 0) q.push_back(in_x);
      if (ph == 5) begin
        if (q.size() == 0) begin
          chk("b2b.queue", 32'd0, 32'd1);
        end else begin
          xp = q.pop_front();
          chk_prod("b2b", xp);
        end
      end
      tick();
      if (ph == 0) in_x = 16'($urandom);
    end
    chk("b2b.left", 32'(q.size()), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
